// File: rtl/epcs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : epcs_pkg
// Brief    : Shared types and constants for the EPCS transmit scheduler.
// Revision : 1.0  initial release
// ============================================================================
package epcs_pkg;

  localparam int WORD_W = 20;

  localparam logic [WORD_W-1:0] TRAIN_WORD_DEF = 20'hF83E0;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF  = 20'h7C1F0;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GNT0  = 2'd2,
    ST_GNT1  = 2'd3
  } state_t;

  // A counter for n values needs at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/epcs_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : epcs_tx_sched_if
// Brief    : Requester handshakes and transmit-side outputs of the scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface epcs_tx_sched_if;
  import epcs_pkg::*;

  logic              train_req;
  logic              s0_valid;
  logic [WORD_W-1:0] s0_data;
  logic              s0_last;
  logic              s0_ready;
  logic              s1_valid;
  logic [WORD_W-1:0] s1_data;
  logic              s1_last;
  logic              s1_ready;
  logic              txvalo;
  logic [WORD_W-1:0] txdout;
  logic              link_up;

  modport master (
    output train_req, s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
    input  s0_ready, s1_ready, txvalo, txdout, link_up
  );

  modport slave (
    input  train_req, s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
    output s0_ready, s1_ready, txvalo, txdout, link_up
  );

endinterface
`default_nettype wire

// File: rtl/epcs_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : epcs_rr_arb2
// Brief    : Two-way round-robin pick; ptr names the requester favoured on a tie.
// Revision : 1.0  initial release
// ============================================================================
module epcs_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt
);

  always_comb begin
    gnt = ptr;
    unique case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ptr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/epcs_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : epcs_tx_sched
// Brief    : Link training and two-requester burst scheduling onto the EPCS tx word stream.
// Revision : 1.0  initial release
// ============================================================================
module epcs_tx_sched
  import epcs_pkg::*;
#(
  parameter int                TRAIN_LEN  = 64,
  parameter int                MAX_BURST  = 16,
  parameter logic [WORD_W-1:0] TRAIN_WORD = TRAIN_WORD_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD  = IDLE_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  epcs_tx_sched_if.slave  bus
);

  localparam int TCW = cnt_width(TRAIN_LEN);
  localparam int BCW = $clog2(MAX_BURST + 1);

  state_t            state, state_nxt;
  logic [TCW-1:0]    tcnt, tcnt_nxt;
  logic [BCW-1:0]    bcnt, bcnt_nxt;
  logic              ptr, ptr_nxt;
  logic              pending, pending_nxt;
  logic              accept;
  logic [WORD_W-1:0] acc_data;

  logic              gnt;
  logic              sel_hi;
  logic              sel_valid;
  logic              sel_last;
  logic [WORD_W-1:0] sel_data;

  epcs_rr_arb2 u_arb (
    .req ({bus.s1_valid, bus.s0_valid}),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign sel_hi    = (state == ST_GNT1);
  assign sel_valid = sel_hi ? bus.s1_valid : bus.s0_valid;
  assign sel_last  = sel_hi ? bus.s1_last  : bus.s0_last;
  assign sel_data  = sel_hi ? bus.s1_data  : bus.s0_data;

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    bcnt_nxt    = bcnt;
    ptr_nxt     = ptr;
    pending_nxt = pending;
    accept      = 1'b0;
    acc_data    = sel_data;

    unique case (state)
      ST_TRAIN: begin
        if (bus.train_req) begin
          tcnt_nxt = '0;
        end else if (tcnt == TCW'(TRAIN_LEN - 1)) begin
          state_nxt = ST_IDLE;
          tcnt_nxt  = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end

      ST_IDLE: begin
        if (pending || bus.train_req) begin
          state_nxt   = ST_TRAIN;
          tcnt_nxt    = '0;
          pending_nxt = 1'b0;
        end else if (bus.s0_valid || bus.s1_valid) begin
          state_nxt = gnt ? ST_GNT1 : ST_GNT0;
          bcnt_nxt  = '0;
          // Favour the other requester on the next tie.
          ptr_nxt   = ~gnt;
        end
      end

      ST_GNT0, ST_GNT1: begin
        // Training requested mid-burst waits for the next IDLE.
        if (bus.train_req) pending_nxt = 1'b1;
        if (sel_valid) begin
          accept   = 1'b1;
          bcnt_nxt = bcnt + 1'b1;
          if (sel_last || (bcnt_nxt == BCW'(MAX_BURST))) state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_TRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_TRAIN;
      tcnt         <= '0;
      bcnt         <= '0;
      ptr          <= 1'b0;
      pending      <= 1'b0;
      bus.txvalo   <= 1'b0;
      bus.txdout   <= '0;
      bus.link_up  <= 1'b0;
      bus.s0_ready <= 1'b0;
      bus.s1_ready <= 1'b0;
    end else begin
      state        <= state_nxt;
      tcnt         <= tcnt_nxt;
      bcnt         <= bcnt_nxt;
      ptr          <= ptr_nxt;
      pending      <= pending_nxt;
      bus.txvalo   <= accept;
      bus.txdout   <= accept ? acc_data : ((state == ST_TRAIN) ? TRAIN_WORD : IDLE_WORD);
      bus.link_up  <= (state != ST_TRAIN);
      // Readys mirror the registered grant state so they never depend on valid.
      bus.s0_ready <= (state_nxt == ST_GNT0);
      bus.s1_ready <= (state_nxt == ST_GNT1);
    end
  end

endmodule
`default_nettype wire

// File: doc/epcs_tx_sched.md
EPCS_TX_SCHED -- requirements
Module: epcs_tx_sched

Interface
REQ-001 SHALL provide parameter TRAIN_LEN, default 64: number of training words sent per training sequence (legal range 1..1024).
REQ-002 SHALL provide parameter MAX_BURST, default 16: maximum data words per grant (legal range 1..255).
REQ-003 SHALL provide parameter TRAIN_WORD, default 20'hF83E0: filler word sent during training.
REQ-004 SHALL provide parameter IDLE_WORD, default 20'h7C1F0: filler word sent when no data is moving.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 train_req  input  1  one-cycle pulse requesting a new training sequence.
REQ-009 s0_valid / s0_data / s0_last  input  1/20/1  requester 0: word valid, word, last word of frame.
REQ-010 s0_ready  output  1  requester 0 word accepted when s0_valid and s0_ready are both high.
REQ-011 s1_valid / s1_data / s1_last / s1_ready  in/in/in/out  1/20/1/1  requester 1, same semantics as requester 0.
REQ-012 txvalo  output  1  txdout carries a data word; low means txdout carries a filler word.
REQ-013 txdout  output  20  word to the EPCS transmit pipeline.
REQ-014 link_up  output  1  high once training is complete, low during training.

Function
REQ-015 SHALL implement the states TRAIN, IDLE, GNT0 and GNT1.
REQ-016 In TRAIN, txdout SHALL be TRAIN_WORD, txvalo 0, both readys 0, and link_up 0.
REQ-017 TRAIN SHALL last exactly TRAIN_LEN cycles, counted by a counter running 0..TRAIN_LEN-1, and then go to IDLE with link_up set to 1.
REQ-018 In IDLE, txdout SHALL be IDLE_WORD, txvalo 0, and both readys 0.
REQ-019 IDLE lasts at least 1 cycle; the next state is chosen by this priority: pending training -> TRAIN; else exactly one valid -> that GNT; else both valid -> the requester not granted last (round robin); else stay in IDLE.
REQ-020 The round-robin pointer SHALL favour s0 after reset and toggle on every grant.
REQ-021 In GNTn, sn_ready SHALL be 1 and the other ready 0; ready SHALL be a function of registered state only, never of valid.
REQ-022 Each accepted word SHALL appear on txdout with txvalo=1 exactly 1 cycle after acceptance; bits pass unmodified.
REQ-023 In GNTn with sn_valid=0, the output for that cycle SHALL be IDLE_WORD with txvalo=0, and the grant is held.
REQ-024 GNTn SHALL go to IDLE after accepting a word with sn_last=1 or after accepting the MAX_BURST-th word, whichever comes first.
REQ-025 The burst counter SHALL clear on entry to GNTn, and its width SHALL be clog2(MAX_BURST+1).
REQ-026 A train_req pulse SHALL set a pending flag that holds until TRAIN is entered.
REQ-027 A train_req received in GNTn SHALL NOT cut the burst short; it takes effect at the following IDLE.
REQ-028 link_up SHALL drop to 0 on the cycle TRAIN is entered.
REQ-029 train_req arriving during TRAIN SHALL restart the training counter at 0.
REQ-030 When last and the burst limit coincide, the block SHALL make a single transition to IDLE.

Reset
REQ-031 While rst=1: state=TRAIN, training counter=0, burst counter=0, pointer=s0, pending=0.
REQ-032 While rst=1: txvalo=0, txdout=20'd0, link_up=0, s0_ready=0, s1_ready=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst, with no data word emitted after reset.
REQ-034 On the first cycle after reset is released, the block SHALL start a full training sequence.

Structure
REQ-035 Package epcs_pkg SHALL hold the state enumeration, the 20-bit word width constant and the TRAIN_WORD/IDLE_WORD defaults.
REQ-036 A sub-module epcs_rr_arb2 SHALL make the 2-way round-robin pick (inputs: req[1:0], pointer; output: grant index).
REQ-037 All outputs SHALL be registered, with no combinational path from any input to txdout or txvalo.

Verification
REQ-038 Release reset, no requests -> 64 cycles of txdout=F83E0 with link_up=0, then link_up=1 and txdout=7C1F0 steadily.
REQ-039 After link_up: s0 sends 3 words A1,A2,A3 (last on A3) -> txvalo=1 for A1..A3 on consecutive cycles, each 1 cycle after acceptance, then IDLE.
REQ-040 s0 and s1 both hold valid with 40-word frames -> grants alternate s0,s1,s0 in bursts of exactly 16 words, with 1 IDLE cycle between bursts.
REQ-041 s1 drops valid for 2 cycles mid-frame -> 2 cycles of 7C1F0 with txvalo=0, s1 keeps its grant, and no word is lost or duplicated.
REQ-042 train_req pulsed at word 5 of a 10-word s0 frame -> all 10 words are sent, then IDLE, then 64 TRAIN words with link_up=0.
REQ-043 rst pulsed mid-burst -> next cycle txvalo=0 and txdout=0, then a full training sequence; a scoreboard confirms no stray data word.
